// File: rtl/d_cache_pkg.sv
// Shared D-cache types: geometry, refill FSM states
// and the set/way line-index helper.
package d_cache_pkg;

  localparam int TAG_W = 28;
  localparam int SET_W = 2;
  localparam int WAY_W = 2;
  localparam int OFF_W = 2;
  localparam int IDX_W = SET_W + WAY_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_COMMIT,
    S_DONE
  } refill_state_t;

  function automatic logic [IDX_W-1:0] line_idx(
    input logic [SET_W-1:0] set,
    input logic [WAY_W-1:0] way
  );
    return {set, way};
  endfunction

endpackage

// File: rtl/d_victim_sel.sv
// Victim way pick: lowest invalid way, else the
// set's round-robin pointer.
module d_victim_sel
  import d_cache_pkg::*;
(
  input  logic [3:0]       valid_i,
  input  logic [WAY_W-1:0] rr_ptr_i,
  output logic [WAY_W-1:0] way_o,
  output logic             use_rr_o
);

  always_comb begin
    way_o    = rr_ptr_i;
    use_rr_o = 1'b0;
    priority case (1'b1)
      !valid_i[0]: way_o = 2'd0;
      !valid_i[1]: way_o = 2'd1;
      !valid_i[2]: way_o = 2'd2;
      !valid_i[3]: way_o = 2'd3;
      default:     use_rr_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/d_sa_refill_ctrl.sv
// D-cache miss refill: victim pick, block fetch,
// array writes, then valid commit and CPU release.
module d_sa_refill_ctrl
  import d_cache_pkg::*;
#(
  parameter int TAG_W  = 28,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_in,
  input  logic [TAG_W-1:0]  tag_id_in,
  input  logic [1:0]        set_id_in,
  input  logic [1:0]        block_offset_in,
  input  logic [15:0]       valid_array_in,
  output logic              busy,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              data_we,
  output logic [3:0]        data_wr_idx,
  output logic [1:0]        data_wr_word,
  output logic [DATA_W-1:0] data_wr_data,
  output logic              tag_we,
  output logic [3:0]        tag_wr_idx,
  output logic [TAG_W-1:0]  tag_wr_data,
  output logic              refill_done,
  output logic [DATA_W-1:0] resp_data
);

  localparam logic [1:0] LAST = 2'(WORDS - 1);

  refill_state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [1:0]        set_q, set_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        way_q, way_d;
  logic              rr_used_q, rr_used_d;
  logic [3:0][1:0]   rr_q, rr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              dwe_q, dwe_d;
  logic [1:0]        dword_q, dword_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              twe_q, twe_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic [1:0] vs_way;
  logic       vs_rr;

  d_victim_sel u_vsel (
    .valid_i  (valid_array_in[{set_id_in, 2'b00} +: 4]),
    .rr_ptr_i (rr_q[set_id_in]),
    .way_o    (vs_way),
    .use_rr_o (vs_rr)
  );

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    set_d     = set_q;
    off_d     = off_q;
    way_d     = way_q;
    rr_used_d = rr_used_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    req_d     = req_q;
    dwe_d     = 1'b0;
    dword_d   = dword_q;
    ddata_d   = ddata_q;
    twe_d     = 1'b0;
    done_d    = 1'b0;
    resp_d    = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_in) begin
          tag_d     = tag_id_in;
          set_d     = set_id_in;
          off_d     = block_offset_in;
          way_d     = vs_way;
          rr_used_d = vs_rr;
          busy_d    = 1'b1;
          req_d     = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          cnt_d   = 2'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rvalid) begin
          dwe_d   = 1'b1;
          dword_d = cnt_q;
          ddata_d = mem_rdata;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == off_q)
            resp_d = mem_rdata;
          if (cnt_q == LAST) begin
            twe_d   = 1'b1;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        if (rr_used_q)
          rr_d[set_q] = rr_q[set_q] + 2'd1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      set_q     <= '0;
      off_q     <= '0;
      way_q     <= '0;
      rr_used_q <= 1'b0;
      rr_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      dwe_q     <= 1'b0;
      dword_q   <= '0;
      ddata_q   <= '0;
      twe_q     <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      set_q     <= set_d;
      off_q     <= off_d;
      way_q     <= way_d;
      rr_used_q <= rr_used_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      dwe_q     <= dwe_d;
      dword_q   <= dword_d;
      ddata_q   <= ddata_d;
      twe_q     <= twe_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
    end
  end

  assign busy         = busy_q;
  assign mem_req      = req_q;
  assign mem_addr     = 32'({tag_q, set_q, 2'b00});
  assign data_we      = dwe_q;
  assign data_wr_idx  = line_idx(set_q, way_q);
  assign data_wr_word = dword_q;
  assign data_wr_data = ddata_q;
  assign tag_we       = twe_q;
  assign tag_wr_idx   = line_idx(set_q, way_q);
  assign tag_wr_data  = tag_q;
  assign refill_done  = done_q;
  assign resp_data    = resp_q;

endmodule

// File: tb/tb_d_sa_refill_ctrl.sv
// Scoreboard bench for the D-cache refill controller.
module tb_d_sa_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_in;
  logic [27:0] tag_id_in;
  logic [1:0]  set_id_in;
  logic [1:0]  block_offset_in;
  logic [15:0] valid_array_in;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        data_we;
  logic [3:0]  data_wr_idx;
  logic [1:0]  data_wr_word;
  logic [31:0] data_wr_data;
  logic        tag_we;
  logic [3:0]  tag_wr_idx;
  logic [27:0] tag_wr_data;
  logic        refill_done;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  d_sa_refill_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_in         (miss_in),
    .tag_id_in       (tag_id_in),
    .set_id_in       (set_id_in),
    .block_offset_in (block_offset_in),
    .valid_array_in  (valid_array_in),
    .busy            (busy),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .data_we         (data_we),
    .data_wr_idx     (data_wr_idx),
    .data_wr_word    (data_wr_word),
    .data_wr_data    (data_wr_data),
    .tag_we          (tag_we),
    .tag_wr_idx      (tag_wr_idx),
    .tag_wr_data     (tag_wr_data),
    .refill_done     (refill_done),
    .resp_data       (resp_data)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [1:0]  word;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  idx;
    logic [27:0] tag;
  } tw_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } dn_t;

  wr_t         wr_q[$];
  tw_t         tw_q[$];
  dn_t         dn_q[$];
  logic [31:0] ad_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int miss_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DUT output event.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    tw_t t;
    dn_t d;
    if (data_we) begin
      if (wr_q.size() == 0) chk("data_we_unexp", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_idx", 64'(data_wr_idx), 64'(w.idx));
        chk("wr_word", 64'(data_wr_word), 64'(w.word));
        chk("wr_data", 64'(data_wr_data), 64'(w.data));
      end
    end
    if (tag_we) begin
      if (tw_q.size() == 0) chk("tag_we_unexp", 1, 0);
      else begin
        t = tw_q.pop_front();
        chk("tag_idx", 64'(tag_wr_idx), 64'(t.idx));
        chk("tag_data", 64'(tag_wr_data), 64'(t.tag));
      end
    end
    if (refill_done) begin
      if (dn_q.size() == 0) chk("done_unexp", 1, 0);
      else begin
        d = dn_q.pop_front();
        chk("resp_data", 64'(resp_data), 64'(d.data));
        if (d.lat >= 0)
          chk("latency", 64'(cyc - miss_cyc), 64'(d.lat));
      end
    end
    if (mem_req && !req_prev) begin
      if (ad_q.size() == 0) chk("req_unexp", 1, 0);
      else chk("mem_addr", 64'(mem_addr),
               64'(ad_q.pop_front()));
    end
    req_prev = mem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [27:0] tag,
                            input logic [1:0]  set,
                            input logic [1:0]  off,
                            input logic [15:0] vld);
    step();
    tag_id_in       = tag;
    set_id_in       = set;
    block_offset_in = off;
    valid_array_in  = vld;
    miss_in         = 1'b1;
    miss_cyc        = cyc;
    step();
    miss_in = 1'b0;
  endtask

  task automatic refill(input logic [27:0] tag,
                        input logic [1:0]  set,
                        input logic [1:0]  off,
                        input logic [15:0] vld,
                        input logic [3:0]  idx,
                        input int          ack_dly,
                        input int          gap,
                        input logic [31:0] base,
                        input int          lat,
                        input bit          poke);
    int n;
    ad_q.push_back({tag, set, 2'b00});
    for (int k = 0; k < 4; k++)
      wr_q.push_back('{idx, 2'(k), base + 32'(k)});
    tw_q.push_back('{idx, tag});
    dn_q.push_back('{base + 32'(off), lat});
    issue_miss(tag, set, off, vld);
    chk("busy_req", 64'(busy), 1);
    for (int i = 0; i < 1 + ack_dly; i++) begin
      chk("req_held", 64'(mem_req), 1);
      step();
    end
    chk("req_at_ack", 64'(mem_req), 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("req_fall", 64'(mem_req), 0);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        miss_in = poke && (k == 1);
        step();
        miss_in = 1'b0;
        chk("busy_gap", 64'(busy), 1);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(k);
      step();
      mem_rvalid = 1'b0;
    end
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("busy_release", 64'(busy), 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    miss_in         = 1'b0;
    tag_id_in       = '0;
    set_id_in       = '0;
    block_offset_in = '0;
    valid_array_in  = '0;
    mem_ack         = 1'b0;
    mem_rvalid      = 1'b0;
    mem_rdata       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req", 64'(mem_req), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_dwe", 64'(data_we), 0);
    chk("rst_twe", 64'(tag_we), 0);
    chk("rst_done", 64'(refill_done), 0);
    chk("rst_resp", 64'(resp_data), 0);
    rst_n = 1'b1;

    refill(28'h0000ABC, 2'd2, 2'd1, 16'h0000, 4'd8,
           0, 0, 32'hA000_0000, 8, 1'b0);
    refill(28'h0000123, 2'd1, 2'd3, 16'h00B0, 4'd6,
           0, 0, 32'hB000_0000, 8, 1'b0);
    refill(28'h0000300, 2'd3, 2'd0, 16'hF000, 4'd12,
           0, 0, 32'hC000_0000, -1, 1'b0);
    refill(28'h0000301, 2'd3, 2'd1, 16'hF000, 4'd13,
           0, 0, 32'hC100_0000, -1, 1'b0);
    refill(28'h0000302, 2'd3, 2'd2, 16'hF000, 4'd14,
           0, 0, 32'hC200_0000, -1, 1'b0);
    refill(28'h0000303, 2'd3, 2'd3, 16'hF000, 4'd15,
           0, 0, 32'hC300_0000, -1, 1'b0);
    refill(28'h0000304, 2'd3, 2'd0, 16'hF000, 4'd12,
           0, 0, 32'hC400_0000, -1, 1'b0);
    refill(28'h0000140, 2'd1, 2'd2, 16'h00F0, 4'd4,
           0, 0, 32'hD000_0000, -1, 1'b0);
    refill(28'h00DEAD0, 2'd0, 2'd2, 16'h0000, 4'd0,
           5, 2, 32'hE000_0000, -1, 1'b1);
    repeat (4) step();
    chk("one_refill_busy", 64'(busy), 0);
    chk("one_refill_req", 64'(mem_req), 0);

    // Abort after two beats.
    ad_q.push_back({28'h0000055, 2'd0, 2'b00});
    wr_q.push_back('{4'd0, 2'd0, 32'hF000_0000});
    issue_miss(28'h0000055, 2'd0, 2'd0, 16'h0000);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hF000_0000 + 32'(k);
      step();
    end
    mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_req", 64'(mem_req), 0);
    chk("abort_dwe", 64'(data_we), 0);
    chk("abort_twe", 64'(tag_we), 0);
    chk("abort_resp", 64'(resp_data), 0);
    chk("abort_addr", 64'(mem_addr), 0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hF000_0002;
    step();
    mem_rdata  = 32'hF000_0003;
    step();
    mem_rvalid = 1'b0;
    repeat (3) step();
    chk("late_busy", 64'(busy), 0);

    refill(28'h0000777, 2'd3, 2'd3, 16'hF000, 4'd12,
           0, 0, 32'h1234_0000, 8, 1'b0);
    repeat (3) step();

    chk("wr_q_empty", 64'(wr_q.size()), 0);
    chk("tw_q_empty", 64'(tw_q.size()), 0);
    chk("dn_q_empty", 64'(dn_q.size()), 0);
    chk("ad_q_empty", 64'(ad_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
